// File: rtl/dcache_controller_pkg.sv
// Shared geometry, address field helpers and FSM encoding for the MEM-stage data cache.
package dcache_controller_pkg;

    localparam int unsigned LINE_NUM     = 16;
    localparam int unsigned LINE_BITS    = 256;
    localparam int unsigned DATA_LEN     = 32;
    localparam int unsigned ADDR_LEN     = 32;
    localparam int unsigned OFFSET_LEN   = $clog2(LINE_BITS / 8);
    localparam int unsigned INDEX_LEN    = $clog2(LINE_NUM);
    localparam int unsigned TAG_LEN      = ADDR_LEN - INDEX_LEN - OFFSET_LEN;
    localparam int unsigned WORD_SEL_LEN = $clog2(LINE_BITS / DATA_LEN);
    localparam int unsigned BYTE_SEL_LEN = $clog2(DATA_LEN / 8);

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate,
        StRefill
    } state_e;

    function automatic logic [TAG_LEN-1:0] addr_tag(input logic [ADDR_LEN-1:0] addr);
        return addr[ADDR_LEN-1 -: TAG_LEN];
    endfunction

    function automatic logic [INDEX_LEN-1:0] addr_index(input logic [ADDR_LEN-1:0] addr);
        return addr[OFFSET_LEN +: INDEX_LEN];
    endfunction

    function automatic logic [WORD_SEL_LEN-1:0] addr_word(input logic [ADDR_LEN-1:0] addr);
        return addr[BYTE_SEL_LEN +: WORD_SEL_LEN];
    endfunction

    // Line-aligned byte address rebuilt from a tag and an index.
    function automatic logic [ADDR_LEN-1:0] line_addr(input logic [TAG_LEN-1:0]   tag,
                                                      input logic [INDEX_LEN-1:0] index);
        return {tag, index, {OFFSET_LEN{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Direct-mapped cache storage: valid/dirty/tag/data arrays, combinational read,
// synchronous word or full-line write.
module dcache_sram
    import dcache_controller_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [INDEX_LEN-1:0]    rd_index_i,
    output logic                    rd_valid_o,
    output logic                    rd_dirty_o,
    output logic [TAG_LEN-1:0]      rd_tag_o,
    output logic [LINE_BITS-1:0]    rd_line_o,
    input  logic                    word_we_i,
    input  logic [INDEX_LEN-1:0]    word_index_i,
    input  logic [WORD_SEL_LEN-1:0] word_sel_i,
    input  logic [DATA_LEN-1:0]     word_data_i,
    input  logic                    line_we_i,
    input  logic [INDEX_LEN-1:0]    line_index_i,
    input  logic [TAG_LEN-1:0]      line_tag_i,
    input  logic [LINE_BITS-1:0]    line_data_i
);

    logic [LINE_NUM-1:0]  valid_q, valid_d;
    logic [LINE_NUM-1:0]  dirty_q, dirty_d;
    logic [TAG_LEN-1:0]   tag_q  [LINE_NUM];
    logic [TAG_LEN-1:0]   tag_d  [LINE_NUM];
    logic [LINE_BITS-1:0] data_q [LINE_NUM];
    logic [LINE_BITS-1:0] data_d [LINE_NUM];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

    // Next array contents: a refill replaces the line clean, a store dirties one word.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (line_we_i) begin
            valid_d[line_index_i] = 1'b1;
            dirty_d[line_index_i] = 1'b0;
            tag_d[line_index_i]   = line_tag_i;
            data_d[line_index_i]  = line_data_i;
        end else if (word_we_i) begin
            data_d[word_index_i][word_sel_i*DATA_LEN +: DATA_LEN] = word_data_i;
            dirty_d[word_index_i] = 1'b1;
        end
    end

    // Only the state bits need clearing on reset; tag/data are qualified by valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_LEN-1:0]  cpu_addr_i,
    input  logic [DATA_LEN-1:0]  cpu_data_i,
    output logic [DATA_LEN-1:0]  cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_LEN-1:0]  mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    state_e               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;
    logic [TAG_LEN-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_LEN-1:0] miss_index_q, miss_index_d;
    logic [WORD_SEL_LEN-1:0] miss_word_q, miss_word_d;
    logic                 miss_we_q, miss_we_d;
    logic [DATA_LEN-1:0]  miss_data_q, miss_data_d;

    logic [TAG_LEN-1:0]      cpu_tag;
    logic [INDEX_LEN-1:0]    cpu_index;
    logic [WORD_SEL_LEN-1:0] cpu_word;
    logic                    rd_valid, rd_dirty;
    logic [TAG_LEN-1:0]      rd_tag;
    logic [LINE_BITS-1:0]    rd_line;
    logic                    idle, hit, line_we, word_we, refill_store;
    logic                    unused_byte_sel;

    assign cpu_tag   = addr_tag(cpu_addr_i);
    assign cpu_index = addr_index(cpu_addr_i);
    assign cpu_word  = addr_word(cpu_addr_i);
    assign unused_byte_sel = ^cpu_addr_i[BYTE_SEL_LEN-1:0];

    assign idle        = (state_q == StIdle);
    assign hit         = cpu_req_i && rd_valid && (rd_tag == cpu_tag);
    assign cpu_stall_o = (cpu_req_i && !hit) || !idle;
    assign cpu_data_o  = (idle && hit && !cpu_we_i) ? rd_line[cpu_word*DATA_LEN +: DATA_LEN] : '0;

    // A store miss commits its latched word into the fresh line during REFILL; the
    // re-evaluated hit in IDLE then rewrites the same value.
    assign refill_store = (state_q == StRefill) && miss_we_q;
    assign word_we      = !rst_i && ((idle && hit && cpu_we_i) || refill_store);

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

    dcache_sram u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_index_i   (cpu_index),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .rd_tag_o     (rd_tag),
        .rd_line_o    (rd_line),
        .word_we_i    (word_we),
        .word_index_i (refill_store ? miss_index_q : cpu_index),
        .word_sel_i   (refill_store ? miss_word_q : cpu_word),
        .word_data_i  (refill_store ? miss_data_q : cpu_data_i),
        .line_we_i    (line_we && !rst_i),
        .line_index_i (miss_index_q),
        .line_tag_i   (miss_tag_q),
        .line_data_i  (mem_data_i)
    );

    // Miss FSM next state and registered memory-side outputs.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        miss_word_d  = miss_word_q;
        miss_we_d    = miss_we_q;
        miss_data_d  = miss_data_q;
        line_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_i && !hit) begin
                    miss_tag_d   = cpu_tag;
                    miss_index_d = cpu_index;
                    miss_word_d  = cpu_word;
                    miss_we_d    = cpu_we_i;
                    miss_data_d  = cpu_data_i;
                    mem_req_d    = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d    = StWriteback;
                        mem_we_d   = 1'b1;
                        mem_addr_d = line_addr(rd_tag, cpu_index);
                        mem_data_d = rd_line;
                    end else begin
                        state_d    = StAllocate;
                        mem_we_d   = 1'b0;
                        mem_addr_d = line_addr(cpu_tag, cpu_index);
                    end
                end
            end
            StWriteback: begin
                // Drop req for one cycle so the fetch is a distinct transaction.
                if (mem_ack_i) begin
                    state_d   = StAllocate;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            StAllocate: begin
                if (mem_req_q && mem_ack_i) begin
                    line_we   = 1'b1;
                    state_d   = StRefill;
                    mem_req_d = 1'b0;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr(miss_tag_q, miss_index_q);
                end
            end
            StRefill: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            miss_word_q  <= '0;
            miss_we_q    <= 1'b0;
            miss_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            miss_word_q  <= miss_word_d;
            miss_we_q    <= miss_we_d;
            miss_data_q  <= miss_data_d;
        end
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- MEM-stage data cache controller; sits directly upstream of the MEM/WB pipeline register.
- Services load/store words from the EX/MEM stage and returns load data to MEM/WB.
- Direct-mapped, write-back, write-allocate cache with a req/ack handshake to off-chip data memory.
- cpu_stall_o drives Data_Stall_i of MEM/WB and the stall inputs of the upstream pipeline registers and PC.

Parameters:
- LINE_NUM, 16, number of cache lines (power of two).
- LINE_BITS, 256, line size in bits (32 bytes).
- DATA_LEN, 32, CPU word width.
- ADDR_LEN, 32, byte address width.
- TAG_LEN, ADDR_LEN - log2(LINE_NUM) - log2(LINE_BITS/8) = 23, tag width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cpu_req_i  in  1  memory access this cycle (MemRead or MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  ADDR_LEN  byte address; bits [1:0] ignored.
- cpu_data_i  in  DATA_LEN  store data.
- cpu_data_o  out  DATA_LEN  load data; valid when cpu_req_i=1, cpu_we_i=0 and cpu_stall_o=0.
- cpu_stall_o  out  1  freeze pipeline.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  ADDR_LEN  line-aligned address (low 5 bits zero).
- mem_data_o  out  LINE_BITS  write-back line data.
- mem_data_i  in  LINE_BITS  fetched line data.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: tag = addr[31:9], index = addr[8:5], word offset = addr[4:2].
- Per-line storage: valid bit, dirty bit, tag, LINE_BITS of data.

Reset (synchronous, rst_i=1 at posedge):
- State goes to IDLE; all valid and dirty bits are cleared.
- mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=0, cpu_data_o=0.
- Reset asserted mid-transaction abandons the transaction. mem_req_o drops the cycle after reset and any late mem_ack_i is ignored.

Hit path:
- hit = cpu_req_i and valid[index] and tag match. Hit is combinational.
- Load hit: cpu_data_o = selected word, same cycle, zero stall.
- Store hit: the word is written and dirty is set at the posedge. No stall.
- cpu_stall_o = (cpu_req_i and not hit) or (state != IDLE).

FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE, miss with line clean or invalid -> ALLOCATE.
- IDLE, miss with line valid and dirty -> WRITEBACK.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o = {old tag, index, 5'b0}, mem_data_o = old line. On mem_ack_i -> ALLOCATE.
- ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o = {new tag, index, 5'b0}. On mem_ack_i, capture mem_data_i into the line, set valid, load tag, clear dirty -> REFILL.
- REFILL: one cycle, stall still high. Next cycle IDLE re-evaluates the access as a hit.
- Miss latency = memory latency + 2 cycles (clean miss), plus the write-back memory latency for a dirty miss.

Handshake rules:
- mem_req_o, mem_we_o, mem_addr_o and mem_data_o are registered and held stable until the cycle mem_ack_i is sampled.
- mem_req_o deasserts for at least one cycle between the WRITEBACK and ALLOCATE transactions.
- mem_ack_i is ignored in IDLE and REFILL.
- The CPU holds its inputs stable while cpu_stall_o=1. The miss address, we and data are latched on leaving IDLE and the latched values are used throughout.
- cpu_req_i=0 in IDLE: no state change; cpu_data_o is don't-care (drive 0).

Decomposition:
- Shared package: LINE_NUM, LINE_BITS, DATA_LEN, ADDR_LEN, the derived tag/index/offset widths, and the FSM state encoding.
- One sub-module: dcache_sram. It holds the tag/valid/dirty/data arrays, with a combinational read port and a synchronous write port that supports word write or full-line write.

Test Plan:
- Reset, then load 0x0000_0040 with memory line = 0x..._DEAD_BEEF at word 0 and ack 3 cycles after req -> stall for 5 cycles, mem_addr_o=0x40, mem_we_o=0, then cpu_data_o=0xDEADBEEF with stall=0.
- Store 0x1234_5678 to 0x44, then load 0x44 -> both hit, no stall, load returns 0x12345678, no mem_req_o.
- After the store, load 0x244 (same index 2, different tag) -> WRITEBACK to 0x40 with dirty line data, then ALLOCATE at 0x240, then hit.
- Load 0x240 when line 2 is clean -> no write-back, single ALLOCATE transaction only.
- rst_i asserted during ALLOCATE before ack -> mem_req_o=0 next cycle, stall=0, a later ack is ignored, and re-access of 0x240 misses.
- Ack delayed 20 cycles -> mem_addr_o and mem_req_o stable every cycle until ack.
